// File: rtl/dcache_tag_port_arbiter_pkg.sv
// Shared types for the dcache tag write-port arbiter.
//  - dcache_tag_arb_state_t : arbiter FSM states (sweep / idle)
//  - derived_cache_config_t : line / sub-line index widths derived from the cache geometry
//  - line_addr()            : places a line index into a byte address, all other bits zero
package dcache_tag_port_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef enum logic {
    TAG_ARB_SWEEP = 1'b0,
    TAG_ARB_IDLE  = 1'b1
  } dcache_tag_arb_state_t;

  typedef struct packed {
    int line_addr_w;
    int sub_line_addr_w;
  } derived_cache_config_t;

  // Line field sits above the word-in-line index and the byte-in-word bits.
  function automatic logic [ADDR_W-1:0] line_addr(input derived_cache_config_t cfg,
                                                  input logic [ADDR_W-1:0] line);
    logic [ADDR_W-1:0] mask;
    mask = (ADDR_W'(1) << cfg.line_addr_w) - ADDR_W'(1);
    return (line & mask) << (cfg.sub_line_addr_w + 2);
  endfunction

endpackage

// File: rtl/dcache_tag_port_arbiter_if.sv
// Bundle of the arbiter's request inputs and tag-bank / status outputs.
//  master : miss handler, invalidation source, flush source (drives requests)
//  slave  : the arbiter (drives acks, status and tag port A)
interface dcache_tag_port_arbiter_if #(
  parameter int WAYS = 2
);
  logic            fill_req;
  logic [31:0]     fill_addr;
  logic [WAYS-1:0] fill_way;
  logic            fill_ack;
  logic            inv_valid;
  logic [31:0]     inv_addr_in;
  logic            inv_ready;
  logic            flush_req;
  logic            flush_busy;
  logic            flush_done;
  logic            lookup_block;
  logic            tag_miss_req;
  logic [31:0]     tag_miss_addr;
  logic [WAYS-1:0] tag_miss_way;
  logic            tag_extern_inv;
  logic [31:0]     tag_inv_addr;

  modport master (
    output fill_req, fill_addr, fill_way, inv_valid, inv_addr_in, flush_req,
    input  fill_ack, inv_ready, flush_busy, flush_done, lookup_block,
           tag_miss_req, tag_miss_addr, tag_miss_way, tag_extern_inv, tag_inv_addr
  );

  modport slave (
    input  fill_req, fill_addr, fill_way, inv_valid, inv_addr_in, flush_req,
    output fill_ack, inv_ready, flush_busy, flush_done, lookup_block,
           tag_miss_req, tag_miss_addr, tag_miss_way, tag_extern_inv, tag_inv_addr
  );
endinterface

// File: rtl/dcache_tag_port_arbiter_fifo.sv
// Small FIFO holding pending line invalidations.
//  clk, rst  : clock, synchronous active-low reset (empties the FIFO)
//  clear_i   : synchronous flush of all entries (wins over push/pop)
//  push_i    : write data_i (accepted when not full, or when popping the same cycle)
//  pop_i     : drop the head (ignored when empty)
//  data_o    : current head, valid when !empty_o
//  empty_o / full_o : occupancy flags
module dcache_tag_port_arbiter_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o,
  output logic                  full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic        do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
    if (clear_i) begin
      wr_d = '0;
      rd_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/dcache_tag_port_arbiter.sv
// Owner of dcache tag-bank write port A. Arbitrates between miss-fill tag
// writes, queued coherence invalidations and a whole-cache invalidation sweep
// (after reset and on flush_req), and blocks tag lookups while sweeping.
//  clk, rst : clock, synchronous active-low reset
//  bus      : slave side of dcache_tag_port_arbiter_if
//             fill_req/addr/way -> fill_ack (same-cycle grant)
//             inv_valid/inv_addr_in <-> inv_ready
//             flush_req -> flush_busy, flush_done pulse; lookup_block
//             tag_miss_req/addr/way, tag_extern_inv/tag_inv_addr to the tag banks
module dcache_tag_port_arbiter
  import dcache_tag_port_arbiter_pkg::*;
#(
  parameter int WAYS            = 2,
  parameter int LINES           = 512,
  parameter int LINE_ADDR_W     = 9,
  parameter int SUB_LINE_ADDR_W = 2,
  parameter int INV_DEPTH       = 4
) (
  input  logic clk,
  input  logic rst,
  dcache_tag_port_arbiter_if.slave bus
);
  localparam derived_cache_config_t CFG = '{line_addr_w: LINE_ADDR_W,
                                            sub_line_addr_w: SUB_LINE_ADDR_W};
  localparam logic [LINE_ADDR_W-1:0] LAST_LINE = LINE_ADDR_W'(LINES - 1);

  dcache_tag_arb_state_t    state_q, state_d;
  logic [LINE_ADDR_W-1:0]   sweep_ctr_q, sweep_ctr_d;
  logic                     flush_busy_q, flush_busy_d;
  logic                     flush_done_q, flush_done_d;

  logic                     q_push, q_pop, q_clear, q_empty, q_full;
  logic [ADDR_W-1:0]        q_head;
  logic [ADDR_W-1:0]        sweep_addr;

  logic                     fill_ack, miss_req, ext_inv, inv_ready, lookup_block;
  logic [ADDR_W-1:0]        inv_addr;
  logic [WAYS-1:0]          fill_way;

  dcache_tag_port_arbiter_fifo #(
    .DATA_WIDTH (ADDR_W),
    .DEPTH      (INV_DEPTH)
  ) u_inv_q (
    .clk     (clk),
    .rst     (rst),
    .clear_i (q_clear),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .data_i  (bus.inv_addr_in),
    .data_o  (q_head),
    .empty_o (q_empty),
    .full_o  (q_full)
  );

  assign sweep_addr = line_addr(CFG, ADDR_W'(sweep_ctr_q));

  always_comb begin
    state_d      = state_q;
    sweep_ctr_d  = sweep_ctr_q;
    flush_busy_d = flush_busy_q;
    flush_done_d = 1'b0;
    fill_ack     = 1'b0;
    miss_req     = 1'b0;
    ext_inv      = 1'b0;
    inv_ready    = 1'b0;
    lookup_block = 1'b1;
    inv_addr     = q_head;
    q_push       = 1'b0;
    q_pop        = 1'b0;
    q_clear      = 1'b0;
    // While in reset every strobe stays at its safe default.
    if (rst) begin
      case (state_q)
        TAG_ARB_SWEEP: begin
          ext_inv     = 1'b1;
          inv_addr    = sweep_addr;
          // Accept and drop: the sweep already invalidates every line.
          inv_ready   = 1'b1;
          sweep_ctr_d = sweep_ctr_q + LINE_ADDR_W'(1);
          if (sweep_ctr_q == LAST_LINE) begin
            state_d      = TAG_ARB_IDLE;
            flush_busy_d = 1'b0;
            flush_done_d = 1'b1;
          end
        end
        TAG_ARB_IDLE: begin
          lookup_block = 1'b0;
          inv_ready    = ~q_full;
          q_push       = bus.inv_valid & ~q_full;
          // A full queue beats fills so invalidations cannot starve.
          if (q_full) begin
            q_pop   = 1'b1;
            ext_inv = 1'b1;
          end else if (bus.fill_req) begin
            fill_ack = 1'b1;
            miss_req = 1'b1;
          end else if (!q_empty) begin
            q_pop   = 1'b1;
            ext_inv = 1'b1;
          end
          if (bus.flush_req) begin
            state_d      = TAG_ARB_SWEEP;
            flush_busy_d = 1'b1;
            q_clear      = 1'b1;
          end
        end
        default: state_d = TAG_ARB_SWEEP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= TAG_ARB_SWEEP;
      sweep_ctr_q  <= '0;
      flush_busy_q <= 1'b1;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_ctr_q  <= sweep_ctr_d;
      flush_busy_q <= flush_busy_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign fill_way            = bus.fill_way;
  assign bus.fill_ack        = fill_ack;
  assign bus.inv_ready       = inv_ready;
  assign bus.flush_busy      = flush_busy_q;
  assign bus.flush_done      = flush_done_q;
  assign bus.lookup_block    = lookup_block;
  assign bus.tag_miss_req    = miss_req;
  assign bus.tag_miss_addr   = bus.fill_addr;
  assign bus.tag_miss_way    = fill_way;
  assign bus.tag_extern_inv  = ext_inv;
  assign bus.tag_inv_addr    = inv_addr;

endmodule
